// File: rtl/qpf_bank_buffer_pkg.sv
// Shared types and constants for the q/p/f ping-pong coefficient buffer.
`ifndef QPF_CLOG2
`define QPF_CLOG2(x) $clog2(x)
`endif

package qpf_bank_buffer_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    READING = 2'd3
  } bank_state_t;

  localparam int BANKS  = 2;
  localparam int DATA_W = 8;

  // A bank counts as occupied once it holds a complete polynomial set.
  function automatic logic is_occupied(input bank_state_t s);
    return (s == FULL) || (s == READING);
  endfunction

endpackage

// File: rtl/qpf_bank_buffer_if.sv
// Producer write stream, party-computation read ports and bank status for qpf_bank_buffer.
interface qpf_bank_buffer_if
  import qpf_bank_buffer_pkg::*;
#(
  parameter int AW = 8
);
  // Write handshake: a beat transfers on a rising clock edge where i_wr_valid and
  // o_wr_ready are both high; o_wr_ready depends only on registered bank state.
  logic              i_wr_valid;
  logic              o_wr_ready;
  logic [DATA_W-1:0] i_wr_q;
  logic [DATA_W-1:0] i_wr_p;
  logic [DATA_W-1:0] i_wr_f;

  logic              i_q_rd;
  logic              i_p_rd;
  logic              i_f_rd;
  logic [AW-1:0]     i_q_addr;
  logic [AW-1:0]     i_p_addr;
  logic [AW-1:0]     i_f_addr;
  logic [DATA_W-1:0] o_q;
  logic [DATA_W-1:0] o_p;
  logic [DATA_W-1:0] o_f;

  logic              o_start;
  logic              i_release;
  logic [1:0]        o_full_banks;
  logic [2*BANKS-1:0] o_dbg_bank_state;

  modport master (
    output i_wr_valid, i_wr_q, i_wr_p, i_wr_f,
    output i_q_rd, i_p_rd, i_f_rd, i_q_addr, i_p_addr, i_f_addr, i_release,
    input  o_wr_ready, o_q, o_p, o_f, o_start, o_full_banks, o_dbg_bank_state
  );

  modport slave (
    input  i_wr_valid, i_wr_q, i_wr_p, i_wr_f,
    input  i_q_rd, i_p_rd, i_f_rd, i_q_addr, i_p_addr, i_f_addr, i_release,
    output o_wr_ready, o_q, o_p, o_f, o_start, o_full_banks, o_dbg_bank_state
  );

endinterface

// File: rtl/qpf_bank_buffer_sdp_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port returning 0 past DEPTH.
module qpf_sdp_ram #(
  parameter int DEPTH = 230,
  parameter int AW    = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_rd,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  // Storage is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= 8'h00;
    end else if (i_rd) begin
      r_rdata <= (int'(i_raddr) < DEPTH) ? r_mem[i_raddr] : 8'h00;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/qpf_bank_buffer.sv
// Two-bank ping-pong store: producer fills bank wb while party computation reads bank rb.
module qpf_bank_buffer
  import qpf_bank_buffer_pkg::*;
#(
  parameter int M  = 230,
  parameter int AW = `QPF_CLOG2(M)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  qpf_bank_buffer_if.slave  bus
);

  bank_state_t r_bank [BANKS];
  bank_state_t w_bank_nxt [BANKS];
  logic          r_wb, w_wb_nxt;
  logic          r_rb, w_rb_nxt;
  logic [AW-1:0] r_wa, w_wa_nxt;
  logic          r_reading, w_reading_nxt;
  logic          r_start, w_start_nxt;
  logic [1:0]    r_full_banks, w_full_nxt;
  logic          w_accept;
  logic          r_q_sel, r_p_sel, r_f_sel;
  logic [7:0]    w_q_rd [BANKS];
  logic [7:0]    w_p_rd [BANKS];
  logic [7:0]    w_f_rd [BANKS];
  logic [2*BANKS-1:0] w_dbg;

  assign bus.o_wr_ready = (r_bank[r_wb] == EMPTY) || (r_bank[r_wb] == FILLING);
  assign w_accept       = bus.i_wr_valid && bus.o_wr_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int b = 0; b < BANKS; b++) r_bank[b] <= EMPTY;
      r_wb         <= 1'b0;
      r_rb         <= 1'b0;
      r_wa         <= '0;
      r_reading    <= 1'b0;
      r_start      <= 1'b0;
      r_full_banks <= 2'd0;
    end else begin
      r_bank       <= w_bank_nxt;
      r_wb         <= w_wb_nxt;
      r_rb         <= w_rb_nxt;
      r_wa         <= w_wa_nxt;
      r_reading    <= w_reading_nxt;
      r_start      <= w_start_nxt;
      r_full_banks <= w_full_nxt;
    end
  end

  // Fill and consume sides touch different banks, so both updates apply in one cycle.
  always_comb begin
    w_bank_nxt    = r_bank;
    w_wb_nxt      = r_wb;
    w_rb_nxt      = r_rb;
    w_wa_nxt      = r_wa;
    w_reading_nxt = r_reading;
    w_start_nxt   = 1'b0;
    w_full_nxt    = 2'd0;
    if (w_accept) begin
      if (r_bank[r_wb] == EMPTY) w_bank_nxt[r_wb] = FILLING;
      if (r_wa == AW'(M - 1)) begin
        w_bank_nxt[r_wb] = FULL;
        w_wa_nxt         = '0;
        w_wb_nxt         = ~r_wb;
      end else begin
        w_wa_nxt = r_wa + AW'(1);
      end
    end
    if (r_reading) begin
      if (bus.i_release) begin
        w_bank_nxt[r_rb] = EMPTY;
        w_rb_nxt         = ~r_rb;
        w_reading_nxt    = 1'b0;
      end
    end else if (r_bank[r_rb] == FULL) begin
      w_bank_nxt[r_rb] = READING;
      w_start_nxt      = 1'b1;
      w_reading_nxt    = 1'b1;
    end
    for (int b = 0; b < BANKS; b++) begin
      if (is_occupied(w_bank_nxt[b])) w_full_nxt = w_full_nxt + 2'd1;
    end
  end

  always_comb begin
    w_dbg = '0;
    for (int b = 0; b < BANKS; b++) w_dbg[2*b +: 2] = r_bank[b];
  end

  assign bus.o_start          = r_start;
  assign bus.o_full_banks     = r_full_banks;
  assign bus.o_dbg_bank_state = w_dbg;

  // Per-port bank select follows the RAM output register, so held data stays consistent.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q_sel <= 1'b0;
      r_p_sel <= 1'b0;
      r_f_sel <= 1'b0;
    end else begin
      if (bus.i_q_rd) r_q_sel <= r_rb;
      if (bus.i_p_rd) r_p_sel <= r_rb;
      if (bus.i_f_rd) r_f_sel <= r_rb;
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic w_we;
    assign w_we = w_accept && (r_wb == 1'(b));

    qpf_sdp_ram #(.DEPTH(M), .AW(AW)) u_q (
      .i_clk, .i_rst_n, .i_we(w_we), .i_waddr(r_wa), .i_wdata(bus.i_wr_q),
      .i_rd(bus.i_q_rd), .i_raddr(bus.i_q_addr), .o_rdata(w_q_rd[b])
    );
    qpf_sdp_ram #(.DEPTH(M), .AW(AW)) u_p (
      .i_clk, .i_rst_n, .i_we(w_we), .i_waddr(r_wa), .i_wdata(bus.i_wr_p),
      .i_rd(bus.i_p_rd), .i_raddr(bus.i_p_addr), .o_rdata(w_p_rd[b])
    );
    qpf_sdp_ram #(.DEPTH(M), .AW(AW)) u_f (
      .i_clk, .i_rst_n, .i_we(w_we), .i_waddr(r_wa), .i_wdata(bus.i_wr_f),
      .i_rd(bus.i_f_rd), .i_raddr(bus.i_f_addr), .o_rdata(w_f_rd[b])
    );
  end

  assign bus.o_q = w_q_rd[r_q_sel];
  assign bus.o_p = w_p_rd[r_p_sel];
  assign bus.o_f = w_f_rd[r_f_sel];

endmodule
